// File: rtl/avalon_rsa_dma.sv
// avalon_rsa_dma: Avalon-MM DMA front end for the byte-serial RSA core.
// Reads N and E once per job, then for each message fetches the word,
// byte-loads it into the core, starts it, byte-unloads the result and
// writes it back to the message's address.
// Optional feature macro: RSA_DMA_IRQ_EN (adds the irq output and IRQ_EN bit).
module avalon_rsa_dma #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        avm_waitrequest,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  output logic                        avm_write,
  input  logic                        avm_readdatavalid,
  input  logic [DATA_W-1:0]           avm_readdata,
  output logic [DATA_W-1:0]           avm_writedata,
  input  logic [1:0]                  avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  output logic                        avs_waitrequest,
  output logic                        core_we,
  output logic                        core_oe,
  output logic                        core_start,
  output logic [1:0]                  core_reg_sel,
  output logic [$clog2(DATA_W/8)-1:0] core_addr,
  output logic [7:0]                  core_data_i,
  input  logic [7:0]                  core_data_o,
  input  logic                        core_ready
`ifdef RSA_DMA_IRQ_EN
  ,
  output logic                        irq
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int CA_W  = $clog2(BYTES);
  localparam int BC_W  = CA_W + 1;
  localparam logic [BC_W-1:0]   LAST_C = BC_W'(BYTES - 1);
  localparam logic [BC_W-1:0]   FULL_C = BC_W'(BYTES);
  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(BYTES);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD     = 4'd1;
  localparam logic [3:0] S_RWAIT  = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_START  = 4'd4;
  localparam logic [3:0] S_CALC   = 4'd5;
  localparam logic [3:0] S_UNLOAD = 4'd6;
  localparam logic [3:0] S_WR     = 4'd7;
  localparam logic [3:0] S_NEXT   = 4'd8;

  // Which word the current read fetches: modulus, exponent or a message.
  localparam logic [1:0] P_N   = 2'd0;
  localparam logic [1:0] P_E   = 2'd1;
  localparam logic [1:0] P_MSG = 2'd2;

  logic [3:0]        state_r;
  logic [1:0]        phase_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  processed_r;
  logic [BC_W-1:0]   byte_cnt_r;
  logic [DATA_W-1:0] rd_buf_r;
  logic [DATA_W-1:0] wr_buf_r;
  logic              busy_r;
  logic              done_r;
  logic              irq_en_r;
  logic              zero_go_r;
  logic              calc_first_r;

  logic              go_s;
  logic              clr_s;
  logic              done_set_s;
  logic [CNT_W-1:0]  processed_inc_s;

  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] w, input logic [CA_W-1:0] i);
    return 8'(w >> {i, 3'b000});
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [CA_W-1:0] i,
                                                 input logic [7:0] b);
    logic [DATA_W-1:0] mask;
    mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {i, 3'b000};
    return (w & ~mask) | ({{(DATA_W-8){1'b0}}, b} << {i, 3'b000});
  endfunction

  function automatic logic [1:0] sel_of(input logic [1:0] p);
    case (p)
      P_N:     return 2'b10;
      P_E:     return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  assign avs_waitrequest = 1'b0;
  assign avm_writedata   = wr_buf_r;

  // CSR0 command decode and completion detection.
  always_comb begin
    go_s            = 1'b0;
    clr_s           = 1'b0;
    processed_inc_s = processed_r + CNT_W'(1);
    if (avs_write && (avs_address == 2'd0)) begin
      go_s  = avs_writedata[0] & ~busy_r;
      clr_s = avs_writedata[2];
    end else begin
      go_s  = 1'b0;
      clr_s = 1'b0;
    end
    done_set_s = zero_go_r | ((state_r == S_NEXT) && (processed_inc_s == count_r));
  end

  // Software-programmed configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r   <= '0;
      count_r  <= '0;
      irq_en_r <= 1'b0;
    end else if (avs_write) begin
      case (avs_address)
`ifdef RSA_DMA_IRQ_EN
        2'd0:    irq_en_r <= avs_writedata[4];
`else
        2'd0:    irq_en_r <= 1'b0;
`endif
        2'd1:    if (!busy_r) base_r  <= ADDR_W'(avs_writedata);
        2'd2:    if (!busy_r) count_r <= CNT_W'(avs_writedata);
        default: ;
      endcase
    end
  end

  // Registered CSR read port, one cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= {27'd0, irq_en_r, 1'b0, done_r, busy_r, 1'b0};
        2'd1:    avs_readdata <= 32'(base_r);
        2'd2:    avs_readdata <= 32'(count_r);
        default: avs_readdata <= 32'(processed_r);
      endcase
    end
  end

`ifdef RSA_DMA_IRQ_EN
  // Interrupt is a registered copy of DONE gated by IRQ_EN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= done_r & irq_en_r;
  end
`endif

  // Job sequencer: drives the master port and the core byte interface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      phase_r      <= P_N;
      addr_r       <= '0;
      processed_r  <= '0;
      byte_cnt_r   <= '0;
      rd_buf_r     <= '0;
      wr_buf_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      zero_go_r    <= 1'b0;
      calc_first_r <= 1'b0;
      avm_address  <= '0;
      avm_read     <= 1'b0;
      avm_write    <= 1'b0;
      core_we      <= 1'b0;
      core_oe      <= 1'b0;
      core_start   <= 1'b0;
      core_reg_sel <= 2'b00;
      core_addr    <= '0;
      core_data_i  <= 8'd0;
    end else begin
      zero_go_r <= 1'b0;
      // A completion in this cycle beats a software clear.
      if (done_set_s)  done_r <= 1'b1;
      else if (clr_s)  done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (go_s) begin
            processed_r <= '0;
            if (count_r != '0) begin
              busy_r      <= 1'b1;
              phase_r     <= P_N;
              addr_r      <= base_r;
              avm_address <= base_r;
              avm_read    <= 1'b1;
              state_r     <= S_RD;
            end else begin
              zero_go_r <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state_r  <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (avm_readdatavalid) begin
            rd_buf_r     <= avm_readdata;
            byte_cnt_r   <= '0;
            core_we      <= 1'b1;
            core_addr    <= '0;
            core_data_i  <= avm_readdata[7:0];
            core_reg_sel <= sel_of(phase_r);
            state_r      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (byte_cnt_r == LAST_C) begin
            core_we     <= 1'b0;
            core_addr   <= '0;
            core_data_i <= 8'd0;
            if (phase_r != P_MSG) begin
              phase_r     <= phase_r + 2'd1;
              addr_r      <= addr_r + STEP_C;
              avm_address <= addr_r + STEP_C;
              avm_read    <= 1'b1;
              state_r     <= S_RD;
            end else begin
              core_start <= 1'b1;
              state_r    <= S_START;
            end
          end else begin
            byte_cnt_r  <= byte_cnt_r + BC_W'(1);
            core_addr   <= core_addr + CA_W'(1);
            core_data_i <= byte_of(rd_buf_r, core_addr + CA_W'(1));
          end
        end
        S_START: begin
          core_start   <= 1'b0;
          calc_first_r <= 1'b1;
          state_r      <= S_CALC;
        end
        S_CALC: begin
          // core_ready may still show the previous idle state right after start.
          calc_first_r <= 1'b0;
          if (!calc_first_r && core_ready) begin
            core_oe    <= 1'b1;
            core_addr  <= '0;
            byte_cnt_r <= '0;
            state_r    <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          // core_data_o lags the presented address by one cycle.
          if (byte_cnt_r != '0) begin
            wr_buf_r <= put_byte(wr_buf_r, CA_W'(byte_cnt_r - BC_W'(1)), core_data_o);
          end
          if (byte_cnt_r == FULL_C) begin
            avm_write   <= 1'b1;
            avm_address <= addr_r;
            state_r     <= S_WR;
          end else begin
            byte_cnt_r <= byte_cnt_r + BC_W'(1);
            if (byte_cnt_r == LAST_C) begin
              core_oe   <= 1'b0;
              core_addr <= '0;
            end else begin
              core_addr <= core_addr + CA_W'(1);
            end
          end
        end
        S_WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state_r   <= S_NEXT;
          end
        end
        S_NEXT: begin
          processed_r <= processed_inc_s;
          if (processed_inc_s == count_r) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            addr_r      <= addr_r + STEP_C;
            avm_address <= addr_r + STEP_C;
            avm_read    <= 1'b1;
            state_r     <= S_RD;
          end
        end
        default: begin
          busy_r     <= 1'b0;
          avm_read   <= 1'b0;
          avm_write  <= 1'b0;
          core_we    <= 1'b0;
          core_oe    <= 1'b0;
          core_start <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
